duty_fader: RTL

- Upstream stage of the LED PWM. Sits between the ALU result register and the PWM duty input.
- Accepts a 4-bit target duty over a valid/ready handshake.
- Ramps its duty output toward the target by one LSB every STEP_PERIODS PWM periods, giving smooth fades instead of hard brightness jumps.
- duty_out connects directly to the PWM's 4-bit duty input.

---
 rtl/duty_fader_pkg.sv | 34 +++
 rtl/period_divider.sv | 36 +++
 rtl/duty_fader.sv | 123 ++++++++++++
 3 files changed

// File: rtl/duty_fader_pkg.sv
// duty_fader_pkg: shared types and constants for the duty fader and its
// period divider. Build option DUTY_FADER_RETARGET_EN is consumed by
// duty_fader.sv only; nothing here changes with it.
package duty_fader_pkg;

  // Default duty width, matching the 4-bit PWM duty input.
  localparam int DUTY_W_DEF = 4;

  // Largest representable duty for the default width.
  localparam int DUTY_MAX = (1 << DUTY_W_DEF) - 1;

  // Ramp direction. IDLE means duty_out already equals the target.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } fade_state_t;

  // Direction a newly accepted target implies, given the current duty.
  // Both operands are unsigned; equal means there is nothing to ramp.
  function automatic fade_state_t pick_dir(input int unsigned target,
                                           input int unsigned duty);
    fade_state_t dir;
    if (target > duty) begin
      dir = UP;
    end else if (target < duty) begin
      dir = DOWN;
    end else begin
      dir = IDLE;
    end
    return dir;
  endfunction

endpackage : duty_fader_pkg

// File: rtl/period_divider.sv
// period_divider: free-running 0..PERIOD_CYCLES-1 counter with a one-cycle
// tick on the last clock of each period. Shared with the PWM so both see
// the same period boundaries.
module period_divider #(
  parameter  int PERIOD_CYCLES = 16,
  localparam int CW            = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] pcnt,
  output logic          period_tick
);

  localparam logic [CW-1:0] PCNT_LAST = CW'(PERIOD_CYCLES - 1);

  logic [CW-1:0] r_pcnt;

  // Period counter: count up and wrap at the last cycle of the period.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state always uses <= so every register samples the
    // pre-edge values of its inputs, independent of statement order.
    if (rst) begin
      r_pcnt <= '0;
    end else if (r_pcnt == PCNT_LAST) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + CW'(1);
    end
  end

  assign pcnt        = r_pcnt;
  // Decoded straight from the register, so it is glitch-free and aligned
  // with the counter value it describes.
  assign period_tick = (r_pcnt == PCNT_LAST);

endmodule : period_divider

// File: rtl/duty_fader.sv
// duty_fader: accepts a target duty over valid/ready and ramps duty_out
// toward it by one LSB every STEP_PERIODS PWM periods.
// Build option: define DUTY_FADER_RETARGET_EN to accept new targets while a
// ramp is in progress (target_ready held high, step cadence preserved).
module duty_fader
  import duty_fader_pkg::*;
#(
  parameter int DUTY_W        = DUTY_W_DEF,
  parameter int PERIOD_CYCLES = 16,
  parameter int STEP_PERIODS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] target_in,
  input  logic              target_valid,
  output logic              target_ready,
  output logic [DUTY_W-1:0] duty_out,
  output logic              busy,
  output logic              period_tick
);

  localparam int PCW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int SCW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [SCW-1:0] SCNT_LAST = SCW'(STEP_PERIODS - 1);

  fade_state_t       r_state;
  logic [DUTY_W-1:0] r_duty;
  logic [DUTY_W-1:0] r_target;
  logic [SCW-1:0]    r_scnt;
  logic              r_busy;
  logic              r_ready;

  // The phase value is only needed by PWM instances sharing the divider.
  logic [PCW-1:0]    w_pcnt_unused;
  logic              w_period_tick;
  logic              w_accept;
  logic              w_step;
  logic [SCW-1:0]    w_scnt_next;
  logic [DUTY_W-1:0] w_duty_stepped;
  fade_state_t       w_accept_state;

  period_divider #(
    .PERIOD_CYCLES (PERIOD_CYCLES)
  ) u_period_divider (
    .clk         (clk),
    .rst         (rst),
    .pcnt        (w_pcnt_unused),
    .period_tick (w_period_tick)
  );

  assign w_accept       = target_valid && target_ready;
  assign w_accept_state = pick_dir(32'(target_in), 32'(r_duty));

  // A step lands on the period tick that completes STEP_PERIODS periods.
  assign w_step      = (r_state != IDLE) && w_period_tick && (r_scnt == SCNT_LAST);
  assign w_scnt_next = (r_scnt == SCNT_LAST) ? '0 : r_scnt + SCW'(1);

  // Candidate duty one LSB toward the target; only committed on a step.
  always_comb begin
    // NOTE: the default assignment first keeps every path driven, so no
    // latch is inferred for the states that do not move the duty.
    w_duty_stepped = r_duty;
    case (r_state)
      UP:      w_duty_stepped = r_duty + DUTY_W'(1);
      DOWN:    w_duty_stepped = r_duty - DUTY_W'(1);
      default: w_duty_stepped = r_duty;
    endcase
  end

  // Ramp FSM: latch targets, count periods, step duty and retire at target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_duty   <= '0;
      r_target <= '0;
      r_scnt   <= '0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b1;
    end else if (w_accept) begin
      // An accept takes priority over a coincident step: the duty holds for
      // this cycle and the direction is recomputed from the current duty.
      r_target <= target_in;
      r_state  <= w_accept_state;
      r_busy   <= (w_accept_state != IDLE);
`ifdef DUTY_FADER_RETARGET_EN
      r_ready  <= 1'b1;
      if ((r_state == IDLE) || (w_accept_state == IDLE)) begin
        // Starting fresh, or nothing left to do: restart the step count.
        r_scnt <= '0;
      end else if (w_period_tick) begin
        // Retargeting mid-ramp keeps the running cadence.
        r_scnt <= w_scnt_next;
      end
`else
      r_ready  <= (w_accept_state == IDLE);
      r_scnt   <= '0;
`endif
    end else if (w_step) begin
      r_scnt <= '0;
      r_duty <= w_duty_stepped;
      // Retire on the same edge the target value appears, so busy falls
      // in the first cycle duty_out shows the target.
      if (w_duty_stepped == r_target) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_ready <= 1'b1;
      end
    end else if ((r_state != IDLE) && w_period_tick) begin
      r_scnt <= w_scnt_next;
    end
  end

`ifdef DUTY_FADER_RETARGET_EN
  // Retarget builds take a new target in any state.
  assign target_ready = 1'b1;
`else
  assign target_ready = r_ready;
`endif
  assign duty_out     = r_duty;
  assign busy         = r_busy;
  assign period_tick  = w_period_tick;

endmodule : duty_fader
